// File: rtl/fft_pkg.sv
// fft_pkg: shared types, bank encodings and size helpers for the FFT sequencer
package fft_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fft_ctrl_state_t;
    localparam logic BANK0_RD = 1'b0;
    localparam logic BANK1_RD = 1'b1;
    function automatic int fft_n(input int m);
        return 2 ** m;
    endfunction
    function automatic int fft_nbfly(input int m);
        return 2 ** (m - 1);
    endfunction
endpackage

// File: rtl/fft_agu_ctrl_if.sv
// fft_agu_ctrl_if: start request plus AGU/write/bank/status signals of the FFT sequencer
interface fft_agu_ctrl_if #(parameter int M = 9);
    logic         start;
    logic [M-1:0] level;
    logic [M-1:0] index;
    logic         rd_en;
    logic         wr_en;
    logic [M-1:0] wr_index;
    logic         bank_sel;
    logic         busy;
    logic         done;
    modport master (input start, output level, index, rd_en, wr_en, wr_index, bank_sel, busy, done);
    modport slave  (output start, input level, index, rd_en, wr_en, wr_index, bank_sel, busy, done);
endinterface

// File: rtl/fft_pipe_delay.sv
// fft_pipe_delay: DEPTH-stage shift register with asynchronous active-low clear
module fft_pipe_delay #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] sr [DEPTH];
    // shift one stage per cycle; reset discards everything in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/fft_agu_ctrl.sv
// fft_agu_ctrl: radix-2 FFT level/index sequencer with write-delay line and ping-pong bank select
module fft_agu_ctrl
    import fft_pkg::*;
#(
    parameter int M        = 9,
    parameter int BFLY_LAT = 4
) (
    input logic            clk,
    input logic            reset_n,
    fft_agu_ctrl_if.master bus
);
    localparam int NBFLY = fft_nbfly(M);
    fft_ctrl_state_t state_q, state_d;
    logic [M-1:0] level_q, level_d, index_q, index_d;
    logic         bank_q, bank_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [M:0]   wr_q;
    logic         last_idx, last_lvl, drain_end, rd_en;
    assign last_idx  = index_q == M'(NBFLY - 1);
    assign last_lvl  = level_q == M'(M - 1);
    assign drain_end = cnt_q == 4'(BFLY_LAT - 1);
    assign rd_en     = state_q == RUN;
    // state and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            level_q <= '0;
            index_q <= '0;
            bank_q  <= BANK0_RD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            index_q <= index_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
        end
    end
    // next state: sweep indices in RUN, let in-flight writes land in DRAIN, then next level or finish
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        index_d = index_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                level_d = '0;
                index_d = '0;
                bank_d  = BANK0_RD;
            end
            RUN: begin
                index_d = last_idx ? '0 : index_q + 1'b1;
                cnt_d   = '0;
                state_d = last_idx ? DRAIN : RUN;
            end
            DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (drain_end) begin
                    state_d = last_lvl ? DONE : RUN;
                    level_d = last_lvl ? level_q : level_q + 1'b1;
                    bank_d  = last_lvl ? bank_q : ~bank_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                level_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    fft_pipe_delay #(.DEPTH(BFLY_LAT), .W(M + 1)) u_wr_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({rd_en, index_q}),
        .q       (wr_q)
    );
    assign bus.level    = level_q;
    assign bus.index    = index_q;
    assign bus.rd_en    = rd_en;
    assign bus.wr_en    = wr_q[M];
    assign bus.wr_index = wr_q[M-1:0];
    assign bus.bank_sel = bank_q;
    assign bus.busy     = state_q == RUN || state_q == DRAIN;
    assign bus.done     = state_q == DONE;
endmodule
